// File: rtl/inst_queue_pkg.sv
// Shared global definitions for the fetch/decode path: zero word, NOP encoding
// and exception-code defaults.
package inst_queue_pkg;

  localparam int unsigned GlobalDataW = 32;
  localparam int unsigned ExcWDefault = 7;

  localparam logic [GlobalDataW-1:0] ZeroWord = 32'h0000_0000;
  // MIPS NOP (sll $0,$0,0) is the all-zero word
  localparam logic [GlobalDataW-1:0] NopInst  = ZeroWord;
  localparam logic [ExcWDefault-1:0] ExcNone  = 7'h00;

  // Number of fetch lanes carrying a valid instruction
  function automatic logic [1:0] lane_count(input logic [1:0] valid);
    return 2'(valid[0]) + 2'(valid[1]);
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Dual-lane instruction queue between fetch and decode: two pushes per cycle,
// one first-word-fall-through pop, flush for redirects.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXC_W  = ExcWDefault
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [DATA_W-1:0]      in_pc0,
  input  logic [DATA_W-1:0]      in_pc1,
  input  logic [DATA_W-1:0]      in_inst0,
  input  logic [DATA_W-1:0]      in_inst1,
  input  logic [EXC_W-1:0]       in_exc0,
  input  logic [EXC_W-1:0]       in_exc1,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_pc,
  output logic [DATA_W-1:0]      out_inst,
  output logic [EXC_W-1:0]       out_except,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 2 * DATA_W + EXC_W;

  // Entry layout: {exc, inst, pc}
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] wr_ptr_lane1;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       push_n;
  logic             push_en;
  logic             pop_en;
  logic [ENTRY_W-1:0] head;

  // Next-state for pointers and occupancy; flush wins over push/pop
  always_comb begin
    push_en      = in_ready && !flush;
    pop_en       = out_valid && out_ready && !flush;
    push_n       = push_en ? lane_count(in_valid) : 2'd0;
    wr_ptr_lane1 = wr_ptr + PTR_W'(in_valid[0]);
    wr_ptr_next  = wr_ptr + PTR_W'(push_n);
    rd_ptr_next  = rd_ptr + PTR_W'(pop_en);
    count_next   = count + CNT_W'(push_n) - CNT_W'(pop_en);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end

  // in_ready/out_valid are precomputed from count_next so they depend only on flops
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      rd_ptr    <= rd_ptr_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      in_ready  <= (count_next <= CNT_W'(DEPTH - 2));
    end
  end

  // Storage is not reset; empty outputs are masked below
  always_ff @(posedge clk) begin
    if (!reset && push_en && in_valid[0]) begin
      mem[wr_ptr] <= {in_exc0, in_inst0, in_pc0};
    end
    if (!reset && push_en && in_valid[1]) begin
      mem[wr_ptr_lane1] <= {in_exc1, in_inst1, in_pc1};
    end
  end

  // First-word-fall-through head with bubble substitution when empty
  always_comb begin
    head       = mem[rd_ptr];
    out_pc     = DATA_W'(ZeroWord);
    out_inst   = DATA_W'(NopInst);
    out_except = EXC_W'(ExcNone);
    if (out_valid) begin
      out_pc     = head[DATA_W-1:0];
      out_inst   = head[2*DATA_W-1:DATA_W];
      out_except = head[ENTRY_W-1:2*DATA_W];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=8, DATA_W=32, EXC_W=7).
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_pc0, in_pc1, in_inst0, in_inst1;
  logic [6:0]  in_exc0, in_exc1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic [6:0]  out_except;
  logic        out_ready;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  int push_seq = 0;
  int pop_seq = 0;

  always #5 clk = ~clk;

  inst_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_exc0(in_exc0), .in_exc1(in_exc1), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_except(out_except), .out_ready(out_ready), .count(count)
  );

  function automatic logic [31:0] pc_of(input int s);
    return 32'h8000_0000 + 32'(s * 4);
  endfunction

  function automatic logic [31:0] inst_of(input int s);
    return 32'h1000_0000 + 32'(s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 2'b00;
    in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0; in_exc0 = '0; in_exc1 = '0;
  endtask

  task automatic set_lanes(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                           input logic [31:0] p1, input logic [31:0] i1,
                           input logic [6:0] e0, input logic [6:0] e1);
    in_valid = v; in_pc0 = p0; in_inst0 = i0; in_pc1 = p1; in_inst1 = i1; in_exc0 = e0; in_exc1 = e1;
  endtask

  task automatic do_reset;
    idle(); reset = 1'b1; tick(); idle();
  endtask

  task automatic push_dual_seq;
    set_lanes(2'b11, pc_of(push_seq), inst_of(push_seq), pc_of(push_seq + 1), inst_of(push_seq + 1), 7'h0, 7'h0);
    tick(); push_seq += 2; idle();
  endtask

  task automatic push_single_seq;
    set_lanes(2'b01, pc_of(push_seq), inst_of(push_seq), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h0, 7'h0);
    tick(); push_seq += 1; idle();
  endtask

  task automatic test_reset;
    idle(); reset = 1'b1; tick(); tick(); idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0 || out_except !== 7'h0) begin errors++; $display("FAIL reset_out_fields got %h/%h/%h want 0/0/0", out_pc, out_inst, out_except); end
  endtask

  task automatic test_dual_push;
    set_lanes(2'b11, 32'hBFC0_0000, 32'h1111_1111, 32'hBFC0_0004, 32'h2222_2222, 7'h0, 7'h0);
    tick(); idle();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL dual_count got %0d want 2", count); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL dual_head got v=%b pc=%h want v=1 pc=bfc00000", out_valid, out_pc); end
    checks++; if (out_inst !== 32'h1111_1111) begin errors++; $display("FAIL dual_inst got %h want 11111111", out_inst); end
    out_ready = 1'b1; tick();
    checks++; if (out_pc !== 32'hBFC0_0004 || out_inst !== 32'h2222_2222) begin errors++; $display("FAIL pop1_head got %h/%h want bfc00004/22222222", out_pc, out_inst); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL pop1_count got %0d want 1", count); end
    tick();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL pop2_empty got cnt=%0d v=%b want 0/0", count, out_valid); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL empty_bubble got %h/%h want 0/0", out_pc, out_inst); end
    tick();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_ignored got cnt=%0d v=%b want 0/0", count, out_valid); end
    idle();
    set_lanes(2'b10, 32'hAAAA_0000, 32'hAAAA_AAAA, 32'h0040_0000, 32'h3333_3333, 7'h11, 7'h22);
    tick(); idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL lane1_count got %0d want 1", count); end
    checks++; if (out_pc !== 32'h0040_0000 || out_inst !== 32'h3333_3333 || out_except !== 7'h22) begin errors++; $display("FAIL lane1_head got %h/%h/%h want 00400000/33333333/22", out_pc, out_inst, out_except); end
    out_ready = 1'b1; tick(); idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL lane1_pop_count got %0d want 0", count); end
  endtask

  task automatic test_exception;
    set_lanes(2'b01, 32'h0000_0100, 32'h0000_ABCD, 32'h0000_0104, 32'h0000_EEEE, 7'h04, 7'h7F);
    tick(); idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL exc_count got %0d want 1", count); end
    checks++; if (out_except !== 7'h04 || out_pc !== 32'h0000_0100 || out_inst !== 32'h0000_ABCD) begin errors++; $display("FAIL exc_head got %h/%h/%h want 04/00000100/0000abcd", out_except, out_pc, out_inst); end
    out_ready = 1'b1; tick(); idle();
    checks++; if (out_except !== 7'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL exc_after_pop got exc=%h v=%b want 0/0", out_except, out_valid); end
  endtask

  task automatic test_fill;
    do_reset(); push_seq = 0; pop_seq = 0;
    for (int k = 0; k < 3; k++) push_dual_seq();
    checks++; if (count !== 4'd6 || in_ready !== 1'b1) begin errors++; $display("FAIL fill6 got cnt=%0d rdy=%b want 6/1", count, in_ready); end
    push_single_seq();
    checks++; if (count !== 4'd7 || in_ready !== 1'b0) begin errors++; $display("FAIL fill7 got cnt=%0d rdy=%b want 7/0", count, in_ready); end
    set_lanes(2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0004, 32'hDEAD_0005, 7'h0, 7'h0);
    tick(); idle();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL blocked_push7 got %0d want 7", count); end
    out_ready = 1'b1; tick(); idle(); pop_seq = 1;
    checks++; if (count !== 4'd6 || in_ready !== 1'b1 || out_pc !== pc_of(1)) begin errors++; $display("FAIL refill6 got cnt=%0d rdy=%b pc=%h want 6/1/%h", count, in_ready, out_pc, pc_of(1)); end
    push_dual_seq();
    checks++; if (count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL full8 got cnt=%0d rdy=%b want 8/0", count, in_ready); end
    set_lanes(2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0004, 32'hDEAD_0005, 7'h0, 7'h0);
    tick(); idle();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL blocked_push8 got %0d want 8", count); end
    for (int k = 0; k < 8; k++) begin
      idle(); out_ready = 1'b1;
      checks++; if (out_valid !== 1'b1 || out_pc !== pc_of(pop_seq) || out_inst !== inst_of(pop_seq)) begin errors++; $display("FAIL drain%0d got v=%b pc=%h inst=%h want 1/%h/%h", k, out_valid, out_pc, out_inst, pc_of(pop_seq), inst_of(pop_seq)); end
      tick(); pop_seq++;
    end
    idle();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drained got cnt=%0d v=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_back_to_back;
    push_dual_seq();
    push_single_seq();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL b2b_start got %0d want 3", count); end
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i % 2 == 0)
        set_lanes(2'b11, pc_of(push_seq), inst_of(push_seq), pc_of(push_seq + 1), inst_of(push_seq + 1), 7'h0, 7'h0);
      out_ready = 1'b1;
      checks++; if (out_pc !== pc_of(pop_seq) || out_inst !== inst_of(pop_seq)) begin errors++; $display("FAIL b2b_order%0d got %h/%h want %h/%h", i, out_pc, out_inst, pc_of(pop_seq), inst_of(pop_seq)); end
      tick(); pop_seq++;
      if (i % 2 == 0) push_seq += 2;
      checks++; if (count !== ((i % 2 == 0) ? 4'd4 : 4'd3)) begin errors++; $display("FAIL b2b_count%0d got %0d want %0d", i, count, (i % 2 == 0) ? 4 : 3); end
    end
    idle();
  endtask

  task automatic test_flush;
    push_single_seq();
    push_single_seq();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d want 5", count); end
    set_lanes(2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0004, 32'hDEAD_0005, 7'h3, 7'h3);
    out_ready = 1'b1; flush = 1'b1;
    tick(); idle();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got cnt=%0d v=%b rdy=%b want 0/0/1", count, out_valid, in_ready); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL flush_bubble got %h/%h want 0/0", out_pc, out_inst); end
    push_seq = 100; pop_seq = 100;
    push_single_seq();
    checks++; if (count !== 4'd1 || out_pc !== pc_of(100)) begin errors++; $display("FAIL post_flush_push got cnt=%0d pc=%h want 1/%h", count, out_pc, pc_of(100)); end
    out_ready = 1'b1; tick(); idle();
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) push_dual_seq();
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL midrst_pre got %0d want 6", count); end
    set_lanes(2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0004, 32'hDEAD_0005, 7'h5, 7'h5);
    out_ready = 1'b1; flush = 1'b1; reset = 1'b1;
    tick(); idle();
    checks++; if (count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_state got cnt=%0d rdy=%b v=%b want 0/1/0", count, in_ready, out_valid); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0 || out_except !== 7'h0) begin errors++; $display("FAIL midrst_fields got %h/%h/%h want 0/0/0", out_pc, out_inst, out_except); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_dual_push();
    test_exception();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two and at least 4.
REQ-002 Parameter DATA_W, default 32, width of PC and instruction words.
REQ-003 Parameter EXC_W, default 7, width of the per-instruction exception code.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-006 flush  in  1  discard all queued and incoming instructions (exception or branch redirect).
REQ-007 in_valid  in  2  per-lane fetch valid; lane0 is older than lane1.
REQ-008 in_pc0 / in_pc1  in  DATA_W  lane PCs.
REQ-009 in_inst0 / in_inst1  in  DATA_W  lane instructions.
REQ-010 in_exc0 / in_exc1  in  EXC_W  lane exception codes.
REQ-011 in_ready  out  1  queue can accept two entries this cycle.
REQ-012 out_valid  out  1  head entry present.
REQ-013 out_pc / out_inst / out_except  out  DATA_W / DATA_W / EXC_W  head entry fields.
REQ-014 out_ready  in  1  decode consumes the head entry this cycle.
REQ-015 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 in_ready SHALL be 1 iff count <= DEPTH-2, evaluated from registered state only and never from in_valid or out_ready.
REQ-017 Push: when in_ready=1 and flush=0, the queue SHALL write the valid lanes in order, lane0 before lane1; in_valid=2'b10 writes a single entry taken from lane1.
REQ-018 When in_ready=0, the queue SHALL write nothing and SHALL leave the fetch data unconsumed; fetch holds its inputs.
REQ-019 Pop: when out_valid=1, out_ready=1 and flush=0, the queue SHALL remove the head entry.
REQ-020 Push and pop in the same cycle SHALL both take effect; count_next = count + pushed - popped.
REQ-021 Outputs SHALL be first-word-fall-through: out_* are driven directly from the head entry, and a pushed entry appears at the outputs on the cycle after the push.
REQ-022 When empty, the queue SHALL drive out_valid=0 and out_pc=0, out_inst=0, out_except=0 (bubble = NOP).
REQ-023 flush=1 SHALL set count to 0 and make the read and write pointers equal on the next edge.
REQ-024 flush=1 SHALL drop same-cycle pushes and pops, and SHALL override in_ready and out_ready.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH with no bubble at the wrap point.
REQ-026 Overflow SHALL be impossible by construction.
REQ-027 out_ready while empty SHALL be ignored, with no pointer movement.

Reset
REQ-028 reset=1 SHALL zero count and both pointers, and SHALL force out_valid=0, out_* = 0 and in_ready=1 on the next edge.
REQ-029 reset SHALL take priority over flush, push and pop.
REQ-030 Storage array contents need not be reset, because outputs are masked when empty.

Structure
REQ-031 ZeroWord, the NOP encoding and the EXC_W default SHALL come from the shared global_define header; no local copies.
REQ-032 The queue SHALL be a single module with no sub-modules; storage is a DEPTH x (2*DATA_W+EXC_W) register array.

Verification
REQ-033 Scenario 1: reset, then push in_valid=2'b11 with pc0=0xBFC00000 and pc1=0xBFC00004 -> next cycle count=2, out_pc=0xBFC00000; pop -> out_pc=0xBFC00004.
REQ-034 Scenario 2: fill with dual pushes and out_ready=0 -> in_ready drops when count=7; further pushes write nothing; count stays <= 8.
REQ-035 Scenario 3: count=3 with simultaneous dual push and pop -> count=4 next cycle; order preserved across pointer wrap over 20 cycles.
REQ-036 Scenario 4: count=5 with flush asserted together with push and pop -> count=0, out_valid=0, out_inst=0 next cycle.
REQ-037 Scenario 5: reset asserted mid-stream at count=6 -> count=0, in_ready=1, out_* = 0 next cycle.
REQ-038 Scenario 6: in_exc0=7'h04 on a single-lane push -> out_except=7'h04 alongside the matching pc/inst.
